dbg_bus_master: RTL and testbench
=================================

Name: dbg_bus_master

Overview:
- Single bus initiator that drives the system bus master port (m_addr/m_wdata/m_size/m_read/m_write, with m_rdata/m_busy/m_error returned).
- Accepts one access command at a time from the debug transport (JTAG DMI front end).
- Runs the strobe/busy handshake, checks alignment, and returns a single response with status.
- Supports address auto-increment for block transfers and keeps a sticky error flag for the host.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum number of cycles a strobe may be held while m_busy is high. Only used when DBG_BUS_TIMEOUT_EN is defined.
- CNT_W, 11: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; high exactly when state==IDLE
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  access address
- cmd_addr_sel  in  1  1=use internal next-address register, ignore cmd_addr
- cmd_autoinc  in  1  advance the next-address register after a successful access
- cmd_size  in  3  0=byte, 1=half, 2=word
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes and for errors other than BUS)
- rsp_err  out  2  00 OK, 01 BUS, 10 ALIGN, 11 TIMEOUT
- next_addr  out  32  internal next-address register
- sticky_err  out  1  set on any non-OK response
- err_clr  in  1  clears sticky_err
- m_addr  out  32  bus address
- m_wdata  out  32  bus write data
- m_size  out  3  bus size
- m_read  out  1  bus read strobe
- m_write  out  1  bus write strobe
- m_rdata  in  32  bus read data
- m_busy  in  1  bus wait
- m_error  in  1  bus decode error

Behaviour:
- One clock domain. Reset is asynchronous, active-low.
- Reset values:
  - state=IDLE, so cmd_ready=1.
  - m_read=0, m_write=0, m_addr=0, m_wdata=0, m_size=2.
  - rsp_valid=0, rsp_rdata=0, rsp_err=00, next_addr=0, sticky_err=0, timeout counter=0.
- Reset asserted mid-access drops both strobes immediately and discards the access; no response is produced.
- State machine has three states: IDLE, ACCESS, RESP. All outputs are registered except cmd_ready.
- IDLE: on cmd_valid&&cmd_ready (cycle T):
  - Effective address EA = cmd_addr_sel ? next_addr : cmd_addr. Latch EA, size, wdata, write and autoinc.
  - Alignment error if size>2, or size==1 && EA[0], or size==2 && EA[1:0]!=0. On error: go to RESP with rsp_err=10; no bus strobe is issued.
  - Otherwise: go to ACCESS. In cycle T+1, m_addr=EA, m_wdata, m_size, and exactly one of m_read or m_write is 1.
- ACCESS: the strobe is held constant while m_busy=1. Completion is the first rising edge at which m_busy==0. At completion:
  - If m_error=1: rsp_err=01.
  - Otherwise rsp_err=00.
  - For reads, rsp_rdata=m_rdata, including 0xDEADBEEF on a decode error. For writes, rsp_rdata=0.
  - Strobes drop to 0 in the following cycle, and state goes to RESP with rsp_valid=1.
  - Zero-wait slave: accept at T, strobe high only in T+1, rsp_valid=1 at T+2.
- next_addr update: on OK completion with autoinc=1, next_addr = EA + (1<<size), with 32-bit wrap (0xFFFFFFFC+4 → 0). Otherwise next_addr = EA. next_addr is unchanged on ALIGN, BUS or TIMEOUT.
- RESP: rsp_valid and rsp_* are held until rsp_ready=1. In that cycle the response is consumed; the next cycle is IDLE with rsp_valid=0.
  - No new command is accepted while in RESP, so throughput is at most one access per 3 cycles.
- sticky_err: set in the cycle any non-OK response is loaded.
  - err_clr clears it.
  - If set and clear occur in the same cycle, set wins.

Optional Feature:
- DBG_BUS_TIMEOUT_EN defined:
  - The counter resets to 0 on entry to ACCESS and increments each cycle the strobe is held with m_busy=1.
  - When the count reaches TIMEOUT_CYCLES, the strobe drops, rsp_err=11, rsp_rdata=0, and state goes to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- Not defined: no counter is built; ACCESS waits indefinitely and code 11 is never produced.

Test Plan:
- Read 0x4000_0004 size 2, slave ready immediately, m_rdata=0x12345678 → m_read high exactly 1 cycle, rsp_valid at T+2, rsp_rdata=0x12345678, rsp_err=00.
- Write 0x1000_0000 with wdata=0xCAFEF00D, m_busy held for 5 cycles → m_write held for 6 cycles with stable addr/wdata, then rsp_err=00.
- Read 0x2000_0000 (bus returns m_error=1, m_rdata=0xDEADBEEF) → rsp_err=01, rsp_rdata=0xDEADBEEF, sticky_err=1; err_clr pulse → sticky_err=0.
- Half-word access at 0x4001_0001 → no strobe ever asserted, rsp_err=10, next_addr unchanged.
- Four word reads: first with cmd_addr=0xFFFF_FFF8, cmd_autoinc=1; remaining three with cmd_addr_sel=1 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; final next_addr=0x8.
- DBG_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=16, m_busy stuck high → strobe drops after 16 busy cycles, rsp_err=11. Also assert rst_n=0 mid-access → strobes 0 immediately, no rsp_valid.

Source files
------------

// File: rtl/dbg_bus_master.sv
// Debug-transport bus initiator: one command at a time, alignment check, address auto-increment, sticky error.
// Optional bus timeout is built only when DBG_BUS_TIMEOUT_EN is defined.
module dbg_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_addr_sel,
    input  logic        cmd_autoinc,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] next_addr,
    output logic        sticky_err,
    input  logic        err_clr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_size,
    output logic        m_read,
    output logic        m_write,
    input  logic [31:0] m_rdata,
    input  logic        m_busy,
    input  logic        m_error
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BUS     = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [2:0]  m_size_q, m_size_d;
    logic        m_read_q, m_read_d, m_write_q, m_write_d;
    logic        autoinc_q, autoinc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic        sticky_q, sticky_d;
    logic [31:0] ea, ea_inc;
    logic        misaligned;
`ifdef DBG_BUS_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{CNT_W'(TIMEOUT_CYCLES)};
`endif

    assign ea         = cmd_addr_sel ? next_addr_q : cmd_addr;
    assign misaligned = (cmd_size > 3'd2) || (cmd_size == 3'd1 && ea[0]) ||
                        (cmd_size == 3'd2 && ea[1:0] != 2'b00);
    // m_addr_q holds the latched EA for the whole access; the add wraps at 32 bits
    assign ea_inc     = m_addr_q + (32'd1 << m_size_q);

    always_comb begin
        state_d     = state_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_size_d    = m_size_q;
        m_read_d    = m_read_q;
        m_write_d   = m_write_q;
        autoinc_d   = autoinc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        next_addr_d = next_addr_q;
        sticky_d    = sticky_q & ~err_clr;
`ifdef DBG_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (misaligned) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_ALIGN;
                    rsp_rdata_d = 32'd0;
                    sticky_d    = 1'b1;
                end else begin
                    state_d   = ACCESS;
                    m_addr_d  = ea;
                    m_wdata_d = cmd_wdata;
                    m_size_d  = cmd_size;
                    m_read_d  = ~cmd_write;
                    m_write_d = cmd_write;
                    autoinc_d = cmd_autoinc;
`ifdef DBG_BUS_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ACCESS: begin
                if (!m_busy) begin
                    state_d     = RESP;
                    m_read_d    = 1'b0;
                    m_write_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_read_q ? m_rdata : 32'd0;
                    if (m_error) begin
                        rsp_err_d = ERR_BUS;
                        sticky_d  = 1'b1;
                    end else begin
                        rsp_err_d   = ERR_OK;
                        next_addr_d = autoinc_q ? ea_inc : m_addr_q;
                    end
                end
`ifdef DBG_BUS_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d     = RESP;
                        m_read_d    = 1'b0;
                        m_write_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = ERR_TIMEOUT;
                        sticky_d    = 1'b1;
                    end
                end
`endif
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_addr_q    <= 32'd0;
            m_wdata_q   <= 32'd0;
            m_size_q    <= 3'd2;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            autoinc_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= ERR_OK;
            next_addr_q <= 32'd0;
            sticky_q    <= 1'b0;
`ifdef DBG_BUS_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_size_q    <= m_size_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            autoinc_q   <= autoinc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            next_addr_q <= next_addr_d;
            sticky_q    <= sticky_d;
`ifdef DBG_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign m_size     = m_size_q;
    assign m_read     = m_read_q;
    assign m_write    = m_write_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign next_addr  = next_addr_q;
    assign sticky_err = sticky_q;
endmodule

// File: tb/tb_dbg_bus_master.sv
// Scoreboard bench for dbg_bus_master: directed commands push expected responses, a monitor pops and compares.
module tb_dbg_bus_master;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_addr_sel = 1'b0, cmd_autoinc = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [2:0]  cmd_size = 3'd2;
    logic        cmd_ready, rsp_valid, sticky_err, m_read, m_write;
    logic        rsp_ready = 1'b1, err_clr = 1'b0;
    logic [31:0] rsp_rdata, next_addr, m_addr, m_wdata;
    logic [1:0]  rsp_err;
    logic [2:0]  m_size;
    logic [31:0] m_rdata = '0;
    logic        m_busy = 1'b0, m_error = 1'b0;

    typedef struct packed { logic [31:0] rdata; logic [1:0] err; } rsp_t;
    rsp_t        exp_q[$];
    logic [31:0] addr_log[$];
    int tests = 0, fails = 0;
    int cyc = 0, acc_cyc = 0, rsp_cyc = 0, first_strb_cyc = 0;
    int rsp_cnt = 0, strb_cnt = 0, unstable = 0, busy_cycles = 0, run = 0;
    logic        prev_strb = 1'b0;
    logic [31:0] prev_addr = '0, prev_wd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbg_bus_master #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_addr_sel(cmd_addr_sel),
        .cmd_autoinc(cmd_autoinc), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .next_addr(next_addr), .sticky_err(sticky_err), .err_clr(err_clr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size), .m_read(m_read), .m_write(m_write),
        .m_rdata(m_rdata), .m_busy(m_busy), .m_error(m_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // slave: holds m_busy for busy_cycles strobe cycles, then completes
    always @(negedge clk) begin
        if (m_read || m_write) begin
            m_busy = (run < busy_cycles);
            run++;
        end else begin
            m_busy = 1'b0;
            run = 0;
        end
    end

    // bus monitor: strobe cycle count, start addresses, stability while held
    always @(negedge clk) begin
        if (m_read || m_write) begin
            strb_cnt++;
            if (!prev_strb) begin
                addr_log.push_back(m_addr);
                first_strb_cyc = cyc;
            end else if (m_addr !== prev_addr || m_wdata !== prev_wd) begin
                unstable++;
            end
        end
        prev_strb = m_read || m_write;
        prev_addr = m_addr;
        prev_wd   = m_wdata;
    end

    // response monitor / scoreboard
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got err=%0d rdata=0x%08h with nothing expected", rsp_err, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic sel, input logic inc,
                         input logic [2:0] sz, input logic [31:0] wd, input logic clr,
                         input logic [31:0] erd, input logic [1:0] eerr, input bit push);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_ready_wait: got 0 expected 1");
            return;
        end
        cmd_write = wr; cmd_addr = addr; cmd_addr_sel = sel; cmd_autoinc = inc;
        cmd_size = sz; cmd_wdata = wd; err_clr = clr; cmd_valid = 1'b1;
        acc_cyc = cyc;
        if (push) exp_q.push_back('{rdata: erd, err: eerr});
        @(posedge clk);
        #1 cmd_valid = 1'b0; err_clr = 1'b0; cmd_addr = 32'h5555_5555;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_wait: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    initial begin
        int s0, l0, u0, r0;
        logic [31:0] exp_addrs [4];
        exp_addrs[0] = 32'hFFFF_FFF8; exp_addrs[1] = 32'hFFFF_FFFC;
        exp_addrs[2] = 32'h0000_0000; exp_addrs[3] = 32'h0000_0004;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_strobes", {30'd0, m_read, m_write}, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_size", 32'(m_size), 2);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_next_addr", next_addr, 0);
        check("rst_sticky", 32'(sticky_err), 0);
        rst_n = 1'b1;

        // zero-wait read
        busy_cycles = 0; m_rdata = 32'h1234_5678; s0 = strb_cnt; l0 = addr_log.size();
        issue(1'b0, 32'h4000_0004, 1'b0, 1'b0, 3'd2, 32'h0, 1'b0, 32'h1234_5678, 2'b00, 1'b1);
        check("rd_m_read_t1", 32'(m_read), 1);
        wait_rsp();
        check("rd_strobe_cycles", 32'(strb_cnt - s0), 1);
        check("rd_addr", addr_log[l0], 32'h4000_0004);
        check("rd_strobe_at_t1", 32'(first_strb_cyc - acc_cyc), 1);
        check("rd_rsp_at_t2", 32'(rsp_cyc - acc_cyc), 2);

        // write with 5 busy cycles
        busy_cycles = 5; s0 = strb_cnt; u0 = unstable;
        issue(1'b1, 32'h1000_0000, 1'b0, 1'b0, 3'd2, 32'hCAFE_F00D, 1'b0, 32'h0, 2'b00, 1'b1);
        check("wr_m_write", {31'd0, m_write}, 1);
        check("wr_m_read", {31'd0, m_read}, 0);
        check("wr_m_addr", m_addr, 32'h1000_0000);
        check("wr_m_wdata", m_wdata, 32'hCAFE_F00D);
        wait_rsp();
        check("wr_strobe_cycles", 32'(strb_cnt - s0), 6);
        check("wr_stable", 32'(unstable - u0), 0);
        check("wr_next_addr", next_addr, 32'h1000_0000);

        // bus decode error on read
        busy_cycles = 0; m_error = 1'b1; m_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 32'h2000_0000, 1'b0, 1'b1, 3'd2, 32'h0, 1'b0, 32'hDEAD_BEEF, 2'b01, 1'b1);
        wait_rsp();
        m_error = 1'b0;
        check("bus_sticky_set", 32'(sticky_err), 1);
        check("bus_next_addr", next_addr, 32'h1000_0000);
        pulse_clr();
        check("bus_sticky_clr", 32'(sticky_err), 0);

        // misaligned half-word with err_clr in the same cycle: set wins
        s0 = strb_cnt;
        issue(1'b0, 32'h4001_0001, 1'b0, 1'b1, 3'd1, 32'h0, 1'b1, 32'h0, 2'b10, 1'b1);
        check("align_sticky_wins", 32'(sticky_err), 1);
        wait_rsp();
        issue(1'b1, 32'h0000_0002, 1'b0, 1'b0, 3'd2, 32'h1, 1'b0, 32'h0, 2'b10, 1'b1);
        wait_rsp();
        issue(1'b0, 32'h0000_0000, 1'b0, 1'b0, 3'd3, 32'h0, 1'b0, 32'h0, 2'b10, 1'b1);
        wait_rsp();
        check("align_no_strobe", 32'(strb_cnt - s0), 0);
        check("align_next_addr", next_addr, 32'h1000_0000);
        pulse_clr();

        // auto-increment block read across the 32-bit wrap
        l0 = addr_log.size();
        for (int i = 0; i < 4; i++) begin
            m_rdata = 32'hA000_0000 + 32'(i);
            issue(1'b0, 32'hFFFF_FFF8, (i != 0), 1'b1, 3'd2, 32'h0, 1'b0, 32'hA000_0000 + 32'(i), 2'b00, 1'b1);
            wait_rsp();
        end
        for (int i = 0; i < 4; i++) check("inc_addr", addr_log[l0 + i], exp_addrs[i]);
        check("inc_next_addr", next_addr, 32'h0000_0008);
        m_rdata = 32'h0000_00AB;
        issue(1'b0, 32'h0, 1'b1, 1'b1, 3'd0, 32'h0, 1'b0, 32'h0000_00AB, 2'b00, 1'b1);
        wait_rsp();
        check("inc_byte_next", next_addr, 32'h0000_0009);
        issue(1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 32'h0, 1'b0, 32'h0, 2'b10, 1'b1);
        wait_rsp();
        check("inc_align_next", next_addr, 32'h0000_0009);
        pulse_clr();
        check("sticky_quiet", 32'(sticky_err), 0);

`ifdef DBG_BUS_TIMEOUT_EN
        busy_cycles = 1000; m_rdata = 32'h1111_1111; s0 = strb_cnt;
        issue(1'b0, 32'h3000_0000, 1'b0, 1'b1, 3'd2, 32'h0, 1'b0, 32'h0, 2'b11, 1'b1);
        wait_rsp();
        check("to_strobe_cycles", 32'(strb_cnt - s0), 16);
        check("to_sticky", 32'(sticky_err), 1);
        check("to_next_addr", next_addr, 32'h0000_0009);
`endif

        // reset in the middle of a stalled access
        busy_cycles = 1000; r0 = rsp_cnt;
        issue(1'b0, 32'h3000_0010, 1'b0, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_strobe_before", 32'(m_read), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_strobe_dropped", {30'd0, m_read, m_write}, 0);
        check("mid_cmd_ready", 32'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_no_rsp", 32'(rsp_cnt - r0), 0);
        check("mid_rsp_valid", 32'(rsp_valid), 0);
        check("mid_next_addr", next_addr, 0);
        check("mid_m_read", 32'(m_read), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
